// File: rtl/soc_if.sv
// ============================================================================
// Module      : soc_if
// Description : Unified memory bus between the CPU core (master) and the
//               shared instruction/data memory (slave).
//               addr  - byte address driven by the master
//               wdata - full-word store data
//               we    - word write strobe (one cycle per store)
//               rdata - combinational read data for addr
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface soc_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

`default_nettype wire

// File: rtl/soc.sv
// ============================================================================
// Module      : soc (with soc_regfile, soc_decode, soc_cpu, soc_mem)
// Description : Multicycle RV32I-subset CPU with one unified word memory.
//               FETCH (MEM_DELAY_CYCLES) -> EXEC (1) -> MEM (MEM_DELAY_CYCLES,
//               LW/SW only) -> FETCH. ECALL/EBREAK/unsupported ops -> HALT.
// Ports       : clk - single clock, rising edge
//               rst - asynchronous active-high reset
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Register file: 32 x 32-bit, two read ports, one write port. x0 reads 0.
module soc_regfile (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        we_i,
    input  wire logic [4:0]  waddr_i,
    input  wire logic [31:0] wdata_i,
    input  wire logic [4:0]  raddr1_i,
    input  wire logic [4:0]  raddr2_i,
    output logic      [31:0] rdata1_o,
    output logic      [31:0] rdata2_o
);
    logic [31:0] w_regs [32];

    for (genvar n = 0; n < 32; n++) begin : registers
        logic [31:0] dout = '0;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout <= '0;
            end else if (we_i && (waddr_i == 5'(n)) && (n != 0)) begin
                dout <= wdata_i;
            end
        end
        assign w_regs[n] = dout;
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : w_regs[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : w_regs[raddr2_i];
endmodule

// Decode: operand fetch from the register file plus immediate extraction.
module soc_decode (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:7] ir_i,
    input  wire logic        rd_we_i,
    input  wire logic [31:0] rd_wdata_i,
    output logic      [31:0] rs1_val_o,
    output logic      [31:0] rs2_val_o,
    output logic      [31:0] imm_i_o,
    output logic      [31:0] imm_s_o,
    output logic      [31:0] imm_b_o,
    output logic      [31:0] imm_u_o,
    output logic      [31:0] imm_j_o
);
    soc_regfile register_file (
        .clk      (clk),
        .rst      (rst),
        .we_i     (rd_we_i),
        .waddr_i  (ir_i[11:7]),
        .wdata_i  (rd_wdata_i),
        .raddr1_i (ir_i[19:15]),
        .raddr2_i (ir_i[24:20]),
        .rdata1_o (rs1_val_o),
        .rdata2_o (rs2_val_o)
    );

    assign imm_i_o = {{20{ir_i[31]}}, ir_i[31:20]};
    assign imm_s_o = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
    assign imm_b_o = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
    assign imm_u_o = {ir_i[31:12], 12'd0};
    assign imm_j_o = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
endmodule

module soc_cpu #(
    parameter int          MEM_DELAY_CYCLES = 4,
    parameter logic [31:0] RESET_PC         = 32'h0000_2000
) (
    input  wire logic clk,
    input  wire logic rst,
    soc_if.master     bus
);
    localparam int             CW       = (MEM_DELAY_CYCLES > 1) ? $clog2(MEM_DELAY_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_DELAY_CYCLES - 1);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_MEM   = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [1:0]    state_q = ST_FETCH;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q   = '0;
    logic [CW-1:0] cnt_d;
    logic [31:0]   pc_q    = RESET_PC;
    logic [31:0]   pc_d;
    logic [31:0]   ir_q    = '0;
    logic [31:0]   ir_d;

    logic [31:0] w_rs1, w_rs2, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_alu_b, w_alu, w_pc4, w_target, w_wb, w_data_addr;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [4:0]  w_sh;
    logic        w_legal, w_taken, w_lt, w_is_mem, w_last, w_writes_rd;
    logic        w_rd_we, w_mem_we;

    assign w_op   = ir_q[6:0];
    assign w_f3   = ir_q[14:12];
    assign w_last = (cnt_q == CNT_LAST);

    soc_decode decode (
        .clk        (clk),
        .rst        (rst),
        .ir_i       (ir_q[31:7]),
        .rd_we_i    (w_rd_we),
        .rd_wdata_i (w_wb),
        .rs1_val_o  (w_rs1),
        .rs2_val_o  (w_rs2),
        .imm_i_o    (w_imm_i),
        .imm_s_o    (w_imm_s),
        .imm_b_o    (w_imm_b),
        .imm_u_o    (w_imm_u),
        .imm_j_o    (w_imm_j)
    );

    // Anything outside the supported subset is treated as a halt request.
    // Branch funct3 values with bit1 clear are exactly BEQ/BNE/BLT/BGE.
    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            OP_LUI, OP_AUIPC, OP_JAL: w_legal = 1'b1;
            OP_JALR:                  w_legal = (w_f3 == 3'b000);
            OP_BRANCH:                w_legal = !w_f3[1];
            OP_LOAD, OP_STORE:        w_legal = (w_f3 == 3'b010);
            OP_IMM, OP_REG:           w_legal = (w_f3 != 3'b011);
            default:                  w_legal = 1'b0;
        endcase
    end

    assign w_writes_rd = (w_op == OP_LUI) || (w_op == OP_AUIPC) || (w_op == OP_JAL) ||
                         (w_op == OP_JALR) || (w_op == OP_IMM) || (w_op == OP_REG);
    assign w_is_mem    = (w_op == OP_LOAD) || (w_op == OP_STORE);

    // ALU: register-register or register-immediate; shifts use bits [4:0].
    assign w_alu_b = (w_op == OP_REG) ? w_rs2 : w_imm_i;
    assign w_sh    = w_alu_b[4:0];
    always_comb begin
        w_alu = 32'd0;
        case (w_f3)
            3'b000:  w_alu = ((w_op == OP_REG) && ir_q[30]) ? (w_rs1 - w_alu_b) : (w_rs1 + w_alu_b);
            3'b001:  w_alu = w_rs1 << w_sh;
            3'b010:  w_alu = {31'd0, $signed(w_rs1) < $signed(w_alu_b)};
            3'b100:  w_alu = w_rs1 ^ w_alu_b;
            3'b101:  w_alu = ir_q[30] ? 32'($signed(w_rs1) >>> w_sh) : (w_rs1 >> w_sh);
            3'b110:  w_alu = w_rs1 | w_alu_b;
            3'b111:  w_alu = w_rs1 & w_alu_b;
            default: w_alu = 32'd0;
        endcase
    end

    assign w_lt = $signed(w_rs1) < $signed(w_rs2);
    always_comb begin
        w_taken = 1'b0;
        case (w_f3)
            3'b000:  w_taken = (w_rs1 == w_rs2);
            3'b001:  w_taken = (w_rs1 != w_rs2);
            3'b100:  w_taken = w_lt;
            3'b101:  w_taken = !w_lt;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_pc4 = pc_q + 32'd4;
    always_comb begin
        w_target = w_pc4;
        case (w_op)
            OP_JAL:    w_target = pc_q + w_imm_j;
            OP_JALR:   w_target = (w_rs1 + w_imm_i) & ~32'd1;
            OP_BRANCH: w_target = w_taken ? (pc_q + w_imm_b) : w_pc4;
            default:   w_target = w_pc4;
        endcase
    end

    always_comb begin
        w_wb = w_alu;
        case (w_op)
            OP_LUI:          w_wb = w_imm_u;
            OP_AUIPC:        w_wb = pc_q + w_imm_u;
            OP_JAL, OP_JALR: w_wb = w_pc4;
            OP_LOAD:         w_wb = bus.rdata;
            default:         w_wb = w_alu;
        endcase
    end

    assign w_data_addr = w_rs1 + ((w_op == OP_STORE) ? w_imm_s : w_imm_i);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        w_rd_we  = 1'b0;
        w_mem_we = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (w_last) begin
                    ir_d    = bus.rdata;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_EXEC: begin
                if (!w_legal) begin
                    state_d = ST_HALT;
                end else if (w_is_mem) begin
                    state_d = ST_MEM;
                end else begin
                    w_rd_we = w_writes_rd;
                    pc_d    = w_target;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                // Both the load writeback and the store commit happen only on
                // the final cycle, so an aborted access leaves no trace.
                if (w_last) begin
                    w_rd_we  = (w_op == OP_LOAD);
                    w_mem_we = (w_op == OP_STORE);
                    cnt_d    = '0;
                    pc_d     = w_pc4;
                    state_d  = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    assign bus.addr  = (state_q == ST_MEM) ? w_data_addr : pc_q;
    assign bus.wdata = w_rs2;
    assign bus.we    = w_mem_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end
endmodule

// Unified word memory; byte address bits above the index wrap.
module soc_mem #(
    parameter int MEM_WORDS = 4096
) (
    input  wire logic clk,
    soc_if.slave      bus
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   data [0:MEM_WORDS-1];
    logic [AW-1:0] w_idx;
    logic          w_unused_addr;

    assign w_idx         = bus.addr[AW+1:2];
    assign w_unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};
    assign bus.rdata     = data[w_idx];

    always_ff @(posedge clk) begin
        if (bus.we) begin
            data[w_idx] <= bus.wdata;
        end
    end
endmodule

module soc #(
    parameter int          MEM_DELAY_CYCLES = 4,
    parameter int          MEM_WORDS        = 4096,
    parameter logic [31:0] RESET_PC         = 32'h0000_2000
) (
    input wire logic clk,
    input wire logic rst
);
    soc_if bus ();

    soc_cpu #(
        .MEM_DELAY_CYCLES (MEM_DELAY_CYCLES),
        .RESET_PC         (RESET_PC)
    ) cpu (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    soc_mem #(
        .MEM_WORDS (MEM_WORDS)
    ) mem (
        .clk (clk),
        .bus (bus)
    );
endmodule

`default_nettype wire

// File: tb/tb_soc.sv
// ============================================================================
// Module      : tb_soc
// Description : Self-checking bench for soc. An instruction-level model
//               retires each instruction after its cycle cost and is compared
//               with the architectural state of the DUT every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soc;
    localparam int          D     = 4;
    localparam logic [31:0] RPC   = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    soc #(.MEM_DELAY_CYCLES(D), .MEM_WORDS(4096), .RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst)
    );

    logic [31:0] dut_regs [32];
    for (genvar g = 0; g < 32; g++) begin : g_tap
        assign dut_regs[g] = dut.cpu.decode.register_file.registers[g].dout;
    end

    // ---------------- instruction-level model ----------------
    logic [31:0] mmem [4096];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    int          m_left;
    bit          m_halt;

    function automatic int cost(input logic [31:0] ins);
        return ((ins[6:0] == 7'h03) || (ins[6:0] == 7'h23)) ? 2 * D + 1 : D + 1;
    endfunction

    task automatic set_rd(input logic [4:0] rd, input logic [31:0] v);
        if (rd != 5'd0) m_regs[rd] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc   = RPC;
        m_halt = 1'b0;
        m_left = cost(mmem[RPC[13:2]]);
    endtask

    task automatic model_retire();
        logic [31:0] ins, a, b, ii, si, bi, ji, nxt, ea;
        logic [4:0]  rd;
        logic [2:0]  f3;
        ins = mmem[m_pc[13:2]];
        rd  = ins[11:7];
        f3  = ins[14:12];
        a   = m_regs[ins[19:15]];
        b   = m_regs[ins[24:20]];
        ii  = {{20{ins[31]}}, ins[31:20]};
        si  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        bi  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ji  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        nxt = m_pc + 32'd4;
        case (ins[6:0])
            7'h37: set_rd(rd, {ins[31:12], 12'h000});
            7'h17: set_rd(rd, m_pc + {ins[31:12], 12'h000});
            7'h6F: begin set_rd(rd, m_pc + 32'd4); nxt = m_pc + ji; end
            7'h67: begin
                if (f3 != 3'd0) m_halt = 1'b1;
                else begin set_rd(rd, m_pc + 32'd4); nxt = (a + ii) & 32'hFFFF_FFFE; end
            end
            7'h63: begin
                case (f3)
                    3'd0: if (a == b) nxt = m_pc + bi;
                    3'd1: if (a != b) nxt = m_pc + bi;
                    3'd4: if ($signed(a) < $signed(b)) nxt = m_pc + bi;
                    3'd5: if ($signed(a) >= $signed(b)) nxt = m_pc + bi;
                    default: m_halt = 1'b1;
                endcase
            end
            7'h03: begin
                ea = a + ii;
                if (f3 != 3'd2) m_halt = 1'b1; else set_rd(rd, mmem[ea[13:2]]);
            end
            7'h23: begin
                ea = a + si;
                if (f3 != 3'd2) m_halt = 1'b1; else mmem[ea[13:2]] = b;
            end
            7'h13, 7'h33: begin
                if (ins[6:0] == 7'h33) ii = b;
                case (f3)
                    3'd0: set_rd(rd, (ins[6:0] == 7'h33 && ins[30]) ? a - ii : a + ii);
                    3'd1: set_rd(rd, a << ii[4:0]);
                    3'd2: set_rd(rd, ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0);
                    3'd4: set_rd(rd, a ^ ii);
                    3'd5: set_rd(rd, ins[30] ? 32'($signed(a) >>> ii[4:0]) : a >> ii[4:0]);
                    3'd6: set_rd(rd, a | ii);
                    3'd7: set_rd(rd, a & ii);
                    default: m_halt = 1'b1;
                endcase
            end
            default: m_halt = 1'b1;
        endcase
        if (!m_halt) m_pc = nxt;
    endtask

    // ---------------- per-cycle compare ----------------
    task automatic compare();
        bit          bad = 1'b0;
        string       what = "";
        logic [31:0] got = '0, exp = '0;
        int          watch [2] = '{64, 3071};
        n_checks++;
        for (int i = 0; i < 32; i++) begin
            if (!bad && dut_regs[i] !== m_regs[i]) begin
                bad = 1'b1; what = $sformatf("x%0d", i); got = dut_regs[i]; exp = m_regs[i];
            end
        end
        if (!bad && dut.cpu.pc_q !== m_pc) begin
            bad = 1'b1; what = "pc"; got = dut.cpu.pc_q; exp = m_pc;
        end
        for (int k = 0; k < 2; k++) begin
            if (!bad && dut.mem.data[watch[k]] !== mmem[watch[k]]) begin
                bad = 1'b1; what = $sformatf("data[%0d]", watch[k]);
                got = dut.mem.data[watch[k]]; exp = mmem[watch[k]];
            end
        end
        if (bad) begin
            n_fail++;
            $display("FAIL model_%s cycle %0d: actual %h required %h", what, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else if (!m_halt) begin
            m_left--;
            if (m_left == 0) begin
                model_retire();
                if (!m_halt) m_left = cost(mmem[m_pc[13:2]]);
            end
        end
        @(negedge clk);
        if (!rst) compare();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, got, exp);
        end
    endtask

    task automatic load(input int idx, input logic [31:0] w);
        dut.mem.data[idx] = w;
        mmem[idx]         = w;
    endtask

    task automatic start_reset();
        #1 rst = 1'b1;
    endtask

    task automatic finish_reset();
        tick();
        #1 rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mmem[i] = 32'd0;

        // auipc a0,3 with reset never asserted
        load(2048, 32'h0000_3517);
        model_reset();
        repeat (D) tick();
        check("auipc_before_exec", dut_regs[10], 32'h0000_0000);
        tick();
        check("auipc_x10", dut_regs[10], 32'h0000_5000);
        repeat (10) tick();

        // sw/lw round trip through a forced base register
        start_reset();
        load(2048, 32'h1234_5537);   // lui  x10,0x12345
        load(2049, 32'h6785_0513);   // addi x10,x10,0x678
        load(2050, 32'hFEA1_2E23);   // sw   x10,-4(x2)
        load(2051, 32'hFFC1_2583);   // lw   x11,-4(x2)
        load(2052, 32'h0000_0073);   // ecall
        finish_reset();
        check("reset_pc", dut.cpu.pc_q, RPC);
        check("reset_x10", dut_regs[10], 32'h0);
        force dut.cpu.decode.register_file.registers[2].dout = 32'h0000_3000;
        m_regs[2] = 32'h0000_3000;
        repeat (18) tick();
        check("sw_not_yet", dut.mem.data[3071], 32'h0);
        tick();
        check("sw_data", dut.mem.data[3071], 32'h1234_5678);
        repeat (2 * D) tick();
        check("lw_not_yet", dut_regs[11], 32'h0);
        tick();
        check("lw_x11", dut_regs[11], 32'h1234_5678);
        repeat (10) tick();

        // branch skip, x0 discard, shift amount wrap, sub
        start_reset();
        release dut.cpu.decode.register_file.registers[2].dout;
        load(2048, 32'hFFF0_0093);   // addi x1,x0,-1
        load(2049, 32'h0000_9463);   // bne  x1,x0,+8
        load(2050, 32'h0070_0293);   // addi x5,x0,7   (skipped)
        load(2051, 32'h0050_0013);   // addi x0,x0,5
        load(2052, 32'h0030_0313);   // addi x6,x0,3
        load(2053, 32'h0213_1393);   // slli x7,x6,33
        load(2054, 32'h4013_0433);   // sub  x8,x6,x1
        load(2055, 32'h0010_0073);   // ebreak
        finish_reset();
        repeat (2 * (D + 1)) tick();
        check("bne_target_pc", dut.cpu.pc_q, 32'h0000_200C);
        repeat (30) tick();
        check("addi_x1", dut_regs[1], 32'hFFFF_FFFF);
        check("skipped_x5", dut_regs[5], 32'h0);
        check("x0_zero", dut_regs[0], 32'h0);
        check("slli33_x7", dut_regs[7], 32'h0000_0006);
        check("sub_x8", dut_regs[8], 32'h0000_0004);
        check("ebreak_pc", dut.cpu.pc_q, 32'h0000_201C);

        // ecall halt
        start_reset();
        load(2048, 32'h0010_0193);   // addi x3,x0,1
        load(2049, 32'h0020_0213);   // addi x4,x0,2
        load(2050, 32'h0000_0073);   // ecall
        load(2051, 32'h0090_0493);   // addi x9,x0,9
        finish_reset();
        repeat (15) tick();
        repeat (120) tick();
        check("halt_pc", dut.cpu.pc_q, 32'h0000_2008);
        check("halt_x4", dut_regs[4], 32'h0000_0002);
        check("halt_x9", dut_regs[9], 32'h0);

        // reset pulse during the MEM phase of a store
        start_reset();
        load(64,   32'hDEAD_BEEF);
        load(2048, 32'h0550_0513);   // addi x10,x0,0x55
        load(2049, 32'h10A0_2023);   // sw   x10,256(x0)
        finish_reset();
        repeat (3 * D) tick();
        start_reset();
        tick();
        check("abort_word", dut.mem.data[64], 32'hDEAD_BEEF);
        check("abort_pc", dut.cpu.pc_q, RPC);
        check("abort_x10", dut_regs[10], 32'h0);
        #1 rst = 1'b0;
        repeat (D) tick();
        check("refetch_pc", dut.cpu.pc_q, RPC);
        tick();
        check("refetch_x10", dut_regs[10], 32'h0000_0055);
        repeat (2 * D) tick();
        check("restore_word_hold", dut.mem.data[64], 32'hDEAD_BEEF);
        tick();
        check("restore_word", dut.mem.data[64], 32'h0000_0055);
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
